skinny_subcells_serial_d2: RTL
==============================

SKINNY_SUBCELLS_SERIAL_D2 -- requirements
Module: skinny_subcells_serial_d2

Interface
REQ-001 SHALL have parameter SBOX_LAT, default 5, meaning the S-box pipeline latency in clock edges from input nibble to registered output.
REQ-002 SHALL have port clk, input, 1, the single clock; all flops are rising-edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to run SubCells on state_in.
REQ-005 SHALL have ports state_in_s0/s1/s2, input, 64 each, Boolean shares of the 64-bit Skinny state; nibble i = bits [4i+3:4i].
REQ-006 SHALL have port fresh, input, 12, fresh randomness, new value every cycle.
REQ-007 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-008 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-009 SHALL have ports state_out_s0/s1/s2, output, 64 each, shares of the substituted state.

Function
REQ-010 SHALL instantiate one 2nd-order HPC2 Skinny-64 S-box pipeline (3 shares x 4 bits in and out, 12-bit Fresh, latency SBOX_LAT) and process the 16 nibbles serially through it.
REQ-011 SHALL drive fresh to the S-box Fresh input unmodified every cycle, whether or not data is in flight.
REQ-012 SHALL implement FSM states IDLE, FEED, DRAIN, DONE; reset state IDLE.
REQ-013 IDLE: on start=1 at edge T, SHALL load state_in shares into internal share registers, clear feed counter, go to FEED.
REQ-014 start SHALL be ignored in FEED, DRAIN, DONE.
REQ-015 FEED: nibble i (i=0..15, LSB nibble first) SHALL be presented to the S-box in cycle T+1+i, sourced from bits [3:0] of shift registers shifted right by 4 each FEED cycle; after i=15, go to DRAIN.
REQ-016 Outside FEED, S-box share inputs SHALL be driven to all-zero shares.
REQ-017 A SBOX_LAT-deep valid shift register SHALL track in-flight nibbles; output nibble i SHALL be captured from the S-box in cycle T+1+i+SBOX_LAT into nibble i of an internal collect register (per share).
REQ-018 DRAIN SHALL exit to DONE on the edge capturing nibble 15 (end of cycle T+21 for SBOX_LAT=5).
REQ-019 On that same edge, state_out_s0/s1/s2 SHALL be loaded from the collect register (including nibble 15); state_out SHALL change on no other edge.
REQ-020 DONE SHALL last exactly one cycle (T+22) with done=1, then return to IDLE; start in DONE is ignored, start in following IDLE cycle accepted.
REQ-021 busy SHALL be 1 in FEED, DRAIN, DONE and 0 in IDLE; start-to-done latency 22 cycles for SBOX_LAT=5, generally 17+SBOX_LAT.
REQ-022 Shares SHALL never be recombined; share j datapath only mixes with share j except inside the S-box.

Reset
REQ-023 rst_n=0 SHALL asynchronously force IDLE, busy=0, done=0, state_out_*=0, counters, valid shift register, share and collect registers to 0.
REQ-024 Reset mid-operation SHALL abort without a done pulse; S-box internal contents at reset release SHALL be discarded (valid register is 0) and never captured.
REQ-025 After rst_n deasserts, the first start SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-026 All shares zero, fresh random, start pulse -> done at T+22; XOR of output shares = 0xCCCCCCCCCCCCCCCC.
REQ-027 Unshared 0x0123456789ABCDEF split into 3 random shares -> XOR of outputs = 0xC6901A2B385D4E7F; each individual share differs from run to run with different fresh.
REQ-028 start held high continuously for 60 cycles -> exactly two operations, done at T+22 and T+45, busy low only in cycles T+23 and T+46.
REQ-029 rst_n pulsed low at cycle T+10 -> busy, done, state_out_* = 0 immediately; no done pulse afterwards; next start yields correct result at 22-cycle latency.
REQ-030 start asserted during FEED and DRAIN with different state_in -> ignored; result reflects first state_in only; state_out stable until done edge.

Source files
------------

// File: rtl/skinny_subcells_serial_d2.sv
// Serial 2nd-order masked Skinny-64 SubCells: 16 nibbles stream through one
// HPC2 S-box pipeline (3 Boolean shares) and are collected back per share.

module skinny_hpc2_and_d2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] a,
    input  logic [2:0] b,
    input  logic [2:0] r,
    output logic [2:0] c
);
    // r[0] = r01, r[1] = r02, r[2] = r12; pair order (0,1)(0,2)(1,0)(1,2)(2,0)(2,1)
    logic [2:0] ab_d, ab_q, a_d, a_q;
    logic [5:0] nar_d, nar_q, br_d, br_q;

    always_comb begin
        ab_d     = a & b;
        a_d      = a;
        nar_d[0] = ~a[0] & r[0];  br_d[0] = b[1] ^ r[0];
        nar_d[1] = ~a[0] & r[1];  br_d[1] = b[2] ^ r[1];
        nar_d[2] = ~a[1] & r[0];  br_d[2] = b[0] ^ r[0];
        nar_d[3] = ~a[1] & r[2];  br_d[3] = b[2] ^ r[2];
        nar_d[4] = ~a[2] & r[1];  br_d[4] = b[0] ^ r[1];
        nar_d[5] = ~a[2] & r[2];  br_d[5] = b[1] ^ r[2];
        c[0] = ab_q[0] ^ nar_q[0] ^ (a_q[0] & br_q[0]) ^ nar_q[1] ^ (a_q[0] & br_q[1]);
        c[1] = ab_q[1] ^ nar_q[2] ^ (a_q[1] & br_q[2]) ^ nar_q[3] ^ (a_q[1] & br_q[3]);
        c[2] = ab_q[2] ^ nar_q[4] ^ (a_q[2] & br_q[4]) ^ nar_q[5] ^ (a_q[2] & br_q[5]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ab_q  <= '0;
            a_q   <= '0;
            nar_q <= '0;
            br_q  <= '0;
        end else begin
            ab_q  <= ab_d;
            a_q   <= a_d;
            nar_q <= nar_d;
            br_q  <= br_d;
        end
    end
endmodule

module skinny_sbox_hpc2_d2 #(
    parameter int unsigned LAT = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2:0][3:0] x,
    input  logic [11:0]     fresh,
    output logic [2:0][3:0] y
);
    // Four stages of b0 ^= NOR(b3,b2), rotating left after the first three.
    // NOR(a,b) = 1^a^b^ab: the constant and linear terms ride a register
    // alongside the gadget so both arrive together; LAT-4 output registers follow.
    localparam int unsigned NOUT = LAT - 4;

    logic [3:0][2:0][3:0] stin, st_out, lin_d, lin_q;
    logic [3:0][2:0]      g_a, g_b;
    logic [2:0]           g_c [4];
    logic [NOUT-1:0][2:0][3:0] dly_d, dly_q;
    logic [3:0] t;

    for (genvar g = 0; g < 4; g++) begin : g_and
        skinny_hpc2_and_d2 u_and (
            .clk   (clk),
            .rst_n (rst_n),
            .a     (g_a[g]),
            .b     (g_b[g]),
            .r     (fresh[3*g +: 3]),
            .c     (g_c[g])
        );
    end

    assign stin = {st_out[2:0], x};
    assign y    = dly_q[NOUT-1];

    always_comb begin
        st_out = '0;
        t      = '0;
        for (int unsigned g = 0; g < 4; g++) begin
            for (int unsigned s = 0; s < 3; s++) begin
                t = {lin_q[g][s][3:1], lin_q[g][s][0] ^ g_c[g][s]};
                st_out[g][s] = (g < 3) ? {t[2:0], t[3]} : t;
            end
        end
    end

    always_comb begin
        lin_d = '0;
        g_a   = '0;
        g_b   = '0;
        for (int unsigned g = 0; g < 4; g++) begin
            for (int unsigned s = 0; s < 3; s++) begin
                g_a[g][s]   = stin[g][s][3];
                g_b[g][s]   = stin[g][s][2];
                lin_d[g][s] = {stin[g][s][3:1],
                               stin[g][s][0] ^ stin[g][s][3] ^ stin[g][s][2] ^ (s == 0)};
            end
        end
        dly_d    = dly_q;
        dly_d[0] = st_out[3];
        for (int unsigned k = 1; k < NOUT; k++) dly_d[k] = dly_q[k-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lin_q <= '0;
            dly_q <= '0;
        end else begin
            lin_q <= lin_d;
            dly_q <= dly_d;
        end
    end
endmodule

module skinny_subcells_serial_d2 #(
    parameter int unsigned SBOX_LAT = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] state_in_s0,
    input  logic [63:0] state_in_s1,
    input  logic [63:0] state_in_s2,
    input  logic [11:0] fresh,
    output logic        busy,
    output logic        done,
    output logic [63:0] state_out_s0,
    output logic [63:0] state_out_s1,
    output logic [63:0] state_out_s2
);
    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_e;

    state_e               state_d, state_q;
    logic [3:0]           feed_cnt_d, feed_cnt_q, out_cnt_d, out_cnt_q;
    logic [2:0][63:0]     sh_d, sh_q, col_d, col_q, so_d, so_q;
    logic [SBOX_LAT-1:0]  vld_d, vld_q;
    logic                 busy_d, busy_q, done_d, done_q;
    logic [2:0][3:0]      sbox_in, sbox_out;

    skinny_sbox_hpc2_d2 #(.LAT(SBOX_LAT)) u_sbox (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (sbox_in),
        .fresh (fresh),
        .y     (sbox_out)
    );

    assign busy         = busy_q;
    assign done         = done_q;
    assign state_out_s0 = so_q[0];
    assign state_out_s1 = so_q[1];
    assign state_out_s2 = so_q[2];

    always_comb begin
        state_d    = state_q;
        feed_cnt_d = feed_cnt_q;
        out_cnt_d  = out_cnt_q;
        sh_d       = sh_q;
        col_d      = col_q;
        so_d       = so_q;
        sbox_in    = '0;
        vld_d      = {vld_q[SBOX_LAT-2:0], state_q == FEED};

        if (state_q == FEED) begin
            for (int unsigned s = 0; s < 3; s++) sbox_in[s] = sh_q[s][3:0];
        end

        // Results arrive in feed order, so collect by shifting in from the top.
        if (vld_q[SBOX_LAT-1]) begin
            for (int unsigned s = 0; s < 3; s++) col_d[s] = {sbox_out[s], col_q[s][63:4]};
            out_cnt_d = out_cnt_q + 4'd1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    sh_d       = {state_in_s2, state_in_s1, state_in_s0};
                    feed_cnt_d = '0;
                    out_cnt_d  = '0;
                    state_d    = FEED;
                end
            end
            FEED: begin
                for (int unsigned s = 0; s < 3; s++) sh_d[s] = {4'h0, sh_q[s][63:4]};
                feed_cnt_d = feed_cnt_q + 4'd1;
                if (feed_cnt_q == 4'd15) state_d = DRAIN;
            end
            DRAIN: begin
                if (vld_q[SBOX_LAT-1] && out_cnt_q == 4'd15) begin
                    so_d    = col_d;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            feed_cnt_q <= '0;
            out_cnt_q  <= '0;
            sh_q       <= '0;
            col_q      <= '0;
            so_q       <= '0;
            vld_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            feed_cnt_q <= feed_cnt_d;
            out_cnt_q  <= out_cnt_d;
            sh_q       <= sh_d;
            col_q      <= col_d;
            so_q       <= so_d;
            vld_q      <= vld_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end
endmodule
